multi_nibble_adder: RTL and testbench

MULTI_NIBBLE_ADDER -- requirements
Module: multi_nibble_adder

---
 rtl/multi_nibble_adder_pkg.sv | 18 +
 rtl/multi_nibble_adder_fa4.sv | 15 +
 rtl/multi_nibble_adder.sv | 125 ++++++++++++
 tb/tb_multi_nibble_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states
// and the counter-width helper.
package multi_nibble_adder_pkg;

  // Width of one arithmetic slice; operands are processed this many bits per clock.
  localparam int SLICE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_e;

  // Nibble counter width; a single-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage : multi_nibble_adder_pkg

// File: rtl/multi_nibble_adder_fa4.sv
// Combinational 4-bit full adder: the single arithmetic slice of the serial adder.
module multi_nibble_adder_fa4
  import multi_nibble_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] s,
  output logic               c_out
);

  // Widen before adding so the carry lands in the extra top bit.
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, c_in};

endmodule : multi_nibble_adder_fa4

// File: rtl/multi_nibble_adder.sv
// Nibble-serial adder: one 4-bit slice is reused for NIBBLES clocks to form
// {c_out, sum} = a + b + c_in, with a one-cycle done pulse per result.
module multi_nibble_adder
  import multi_nibble_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         done
);

  localparam int               CNT_W    = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [W-1:0]       a_sh_q,   a_sh_d;
  logic [W-1:0]       b_sh_q,   b_sh_d;
  logic [W-1:0]       sum_sh_q, sum_sh_d;
  logic               carry_q,  carry_d;
  logic [W-1:0]       sum_q,    sum_d;
  logic               c_out_q,  c_out_d;
  logic               done_q,   done_d;

  logic [SLICE_W-1:0]   slice_s;
  logic                 slice_c;
  logic [W+SLICE_W-1:0] sum_cat;
  logic [W-1:0]         sum_shifted;

  // The one and only adder: low nibbles of both operand shifters plus the carry.
  multi_nibble_adder_fa4 u_slice (
    .a     (a_sh_q[SLICE_W-1:0]),
    .b     (b_sh_q[SLICE_W-1:0]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // New slice result enters at the top; after NIBBLES shifts the low nibble
  // computed first sits at bit 0. Concatenating first keeps this valid for W = 4.
  assign sum_cat     = {slice_s, sum_sh_q};
  assign sum_shifted = sum_cat[W+SLICE_W-1:SLICE_W];

  // Next-state and datapath control for the IDLE/ADD sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d   = a_sh_q >> SLICE_W;
        b_sh_d   = b_sh_q >> SLICE_W;
        sum_sh_d = sum_shifted;
        carry_d  = slice_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = sum_shifted;
          c_out_d = slice_c;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All sequential state in one register bank with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      done_q   <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign done  = done_q;

endmodule : multi_nibble_adder

// File: tb/tb_multi_nibble_adder.sv
// Self-checking bench for multi_nibble_adder: a 4-nibble instance driven by a
// vector table, hand sequences and random back-to-back traffic, plus a
// 1-nibble instance checked exhaustively.
module tb_multi_nibble_adder;

  localparam int N  = 4;
  localparam int W  = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, sum;
  logic         c_in, ready, c_out, done;

  logic         start1;
  logic [3:0]   a1, b1, sum1;
  logic         c_in1, ready1, c_out1, done1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[9];

  multi_nibble_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .ready (ready),
    .sum   (sum),
    .c_out (c_out),
    .done  (done)
  );

  multi_nibble_adder #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .c_in  (c_in1),
    .ready (ready1),
    .sum   (sum1),
    .c_out (c_out1),
    .done  (done1)
  );

  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit unsigned addition.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation from IDLE, with a stray start pulse while busy; expects a
  // single done exactly N edges after the accepting edge and a held sum before it.
  task automatic run_vec(input vec_t v);
    int           lat;
    int           dones;
    logic         held_ok;
    logic [W-1:0] prev_sum;
    prev_sum = sum;
    held_ok  = 1'b1;
    lat      = 0;
    dones    = 0;
    a = v.a; b = v.b; c_in = v.cin; start = 1'b1;
    step();
    check("busy_after_accept", ready, 1'b0);
    for (int c = 1; c <= N + 2; c++) begin
      if (c == 2) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); c_in = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        dones++;
        if (lat == 0) lat = c;
      end else if (lat == 0 && sum !== prev_sum) begin
        held_ok = 1'b0;
      end
    end
    check("latency", lat, N);
    check("done_count", dones, 1);
    check("result", {c_out, sum}, {v.co, v.s});
    check("sum_held_until_done", held_ok, 1'b1);
    check("ready_after_done", ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra[12];
    logic [W-1:0] rb[12];
    logic         rc[12];
    int           lat;
    int           dones;
    logic [4:0]   exp5;

    vecs[0] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, s: 16'h0000, co: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, co: 1'b1};
    vecs[2] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, s: 16'h5556, co: 1'b0};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, co: 1'b1};
    vecs[4] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, co: 1'b1};
    vecs[5] = '{a: 16'h0F0F, b: 16'hF0F0, cin: 1'b0, s: 16'hFFFF, co: 1'b0};
    vecs[6] = '{a: 16'h0F0F, b: 16'hF0F0, cin: 1'b1, s: 16'h0000, co: 1'b1};
    vecs[7] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0};
    vecs[8] = '{a: 16'hABCD, b: 16'h1111, cin: 1'b0, s: 16'hBCDE, co: 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_sum", sum, 16'h0000);
    check("reset_c_out", c_out, 1'b0);

    // Release reset just after an edge; the first start goes in on the very next edge.
    step();
    rst = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back: start held high, new operands presented in each done cycle.
    // The accepting edge is the one after done, so results are N+1 edges apart.
    for (int k = 0; k < 12; k++) begin
      ra[k] = W'($urandom);
      rb[k] = W'($urandom);
      rc[k] = 1'($urandom);
    end
    ra[0] = 16'hFFFF; rb[0] = 16'hFFFF; rc[0] = 1'b1;
    a = ra[0]; b = rb[0]; c_in = rc[0]; start = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      lat = 0;
      for (int c = 1; c <= N + 3 && lat == 0; c++) begin
        step();
        if (done) lat = c;
      end
      check("b2b_interval", lat, (k == 0) ? N : N + 1);
      check("b2b_result", {c_out, sum}, model(ra[k], rb[k], rc[k]));
      if (k < 11) begin
        a = ra[k+1]; b = rb[k+1]; c_in = rc[k+1];
      end else begin
        start = 1'b0;
      end
    end
    step();
    step();

    // Reset during the second ADD cycle of 0xFFFF + 0xFFFF.
    a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 16'h0000);
    check("abort_c_out", c_out, 1'b0);
    step();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < N + 2; c++) begin
      step();
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_sum_stays", {c_out, sum}, 17'h0);

    // Start on the first edge after a fresh reset release.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_vec(vecs[2]);

    // Single-nibble build: exhaustive, done one edge after each accepting edge.
    for (int i = 0; i < 512; i++) begin
      a1 = i[3:0]; b1 = i[7:4]; c_in1 = i[8]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      exp5 = {1'b0, a1} + {1'b0, b1} + {4'b0, c_in1};
      step();
      check("n1_done_result", {done1, c_out1, sum1}, {1'b1, exp5});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_multi_nibble_adder
